router_fsm_np: RTL
==================

Name: router_fsm_np

Overview:
Parametrised control FSM for an N-output packet router. It is the successor to the fixed 1x3 router controller. It decodes the destination address from the header byte and sequences header, payload and parity loads into the selected output FIFO. It handles FIFO-full back-pressure, per-port soft reset, invalid-address packet dropping and a bounded wait-for-empty timeout. It sits between the input register block (which holds parity, low_pkt_valid and parity_done) and the per-port synchroniser/FIFO bank.

Parameters:
NUM_PORTS, 3, number of output ports (2..8)
ADDR_W, 2, width of the address field in data_in; must satisfy 2**ADDR_W >= NUM_PORTS
WAIT_LIMIT, 32, maximum cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
pkt_valid  input  1  source packet-valid strobe
data_in  input  ADDR_W  address field of the current input byte (header bits [ADDR_W-1:0])
fifo_full  input  NUM_PORTS  per-port FIFO full flags
fifo_empty  input  NUM_PORTS  per-port FIFO empty flags
soft_rst  input  NUM_PORTS  per-port soft-reset pulses from the synchroniser
parity_done  input  1  parity byte has been captured
low_pkt_valid  input  1  pkt_valid fell while FIFO was full
busy  output  1  stall request to source
detect_addr  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
write_enb_reg  output  1  write-enable to input register block
drop_state  output  1  in DROP_PACKET
dest_port  output  ADDR_W  latched destination of current packet
drop_cnt  output  CNT_W  saturating count of dropped packets

Behaviour:
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE), DROP_PACKET (DROP).
- Reset (rst=1 at clock edge): state=DA, dest_port=0, wait counter=0, drop_cnt=0. Resulting outputs: detect_addr=1, all other 1-bit outputs 0. Reset mid-packet aborts immediately. drop_cnt is cleared only by rst.
- Priority per cycle: rst > soft_rst[dest_port] (in any state except DA, next state=DA) > normal transitions.
- DA, when pkt_valid=1:
  - data_in >= NUM_PORTS -> DROP.
  - data_in < NUM_PORTS and fifo_empty[data_in]=1 -> LFD.
  - data_in < NUM_PORTS and fifo_empty[data_in]=0 -> WTE.
  - dest_port <= data_in whenever DA and pkt_valid=1.
  - pkt_valid=0 -> stay in DA.
- LFD -> LD unconditionally.
- LD:
  - fifo_full[dest_port]=1 -> FFS.
  - else pkt_valid=0 -> LP.
  - else stay.
- FFS: fifo_full[dest_port]=0 -> LAF; else stay.
- LAF:
  - parity_done=1 -> DA.
  - parity_done=0 and low_pkt_valid=1 -> LP.
  - parity_done=0 and low_pkt_valid=0 -> LD.
- LP -> CPE unconditionally.
- CPE: fifo_full[dest_port]=1 -> FFS; else DA.
- WTE:
  - Counter cleared on entry, increments each cycle in WTE.
  - fifo_empty[dest_port]=1 -> LFD. Empty takes priority over timeout in the same cycle.
  - Else, with WAIT_LIMIT!=0, counter reaching WAIT_LIMIT-1 -> DROP, giving exactly WAIT_LIMIT cycles in WTE.
- DROP:
  - Stay while pkt_valid=1; pkt_valid=0 -> DA.
  - drop_cnt increments by 1 on each entry to DROP and saturates at all-ones.
- Outputs are Moore, decoded from the current state:
  - write_enb_reg = LD|LP|LAF.
  - busy = LFD|LP|FFS|LAF|WTE|CPE. busy=0 in DA, LD and DROP, so the source drains a dropped packet unstalled.
  - drop_state = DROP.
- Unused state encodings recover to DA on the next clock.

Test Plan:
- rst=1 for 2 cycles, release -> detect_addr=1, busy=0, write_enb_reg=0, drop_cnt=0, dest_port=0.
- Normal packet: pkt_valid=1, data_in=1, fifo_empty=3'b010, hold pkt_valid 3 cycles then 0 -> state sequence DA,LFD,LD,LD,LP,CPE,DA; write_enb_reg=1 in LD/LP; rst_int_reg=1 for one cycle.
- Back-pressure: in LD raise fifo_full[1] for 2 cycles, then low_pkt_valid=1, parity_done=0 -> LD,FFS,FFS,LAF,LP,CPE,DA; busy=1 in FFS/LAF.
- Wait timeout: WAIT_LIMIT=4, data_in=2, fifo_empty[2]=0 held -> 4 cycles in WTE, then DROP, drop_cnt=1, busy=0 while pkt_valid=1. A repeat with fifo_empty[2] rising on the 3rd WTE cycle -> LFD and no drop.
- Invalid address: NUM_PORTS=3, data_in=3, pkt_valid=1 -> DROP next cycle, drop_state=1, write_enb_reg=0; pkt_valid=0 -> DA. With CNT_W=2, 5 drops -> drop_cnt=3.
- Soft reset: in LD with dest_port=1 pulse soft_rst[1] -> DA next cycle. soft_rst[0] pulsed in the same state -> no effect.

Source files
------------

// File: rtl/router_fsm_np_if.sv
// rtl/router_fsm_np_if.sv - control bus between input block, FIFO bank and router FSM
interface router_fsm_np_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int CNT_W     = 8
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 busy;
    logic                 detect_addr;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 drop_state;
    logic [ADDR_W-1:0]    dest_port;
    logic [CNT_W-1:0]     drop_cnt;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_rst,
               parity_done, low_pkt_valid,
        input  busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, drop_state, dest_port, drop_cnt
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_rst,
               parity_done, low_pkt_valid,
        output busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, drop_state, dest_port, drop_cnt
    );
endinterface

// File: rtl/router_fsm_np.sv
// rtl/router_fsm_np.sv - N-port packet router control FSM with drop and wait timeout
module router_fsm_np #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 32,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    router_fsm_np_if.slave bus
);
    localparam int PAD    = 2**ADDR_W;
    localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [3:0] {
        DA   = 4'd0,
        LFD  = 4'd1,
        LD   = 4'd2,
        LP   = 4'd3,
        FFS  = 4'd4,
        LAF  = 4'd5,
        WTE  = 4'd6,
        CPE  = 4'd7,
        DROP = 4'd8
    } state_t;

    state_t            state;
    state_t            next_state;
    state_t            out_state;
    logic [ADDR_W-1:0] dest_port_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic busy_q, detect_addr_q, lfd_q, ld_q, laf_q, full_q;
    logic rst_int_q, write_enb_q, drop_q;

    // Per-port flags widened to the full address space so an out-of-range
    // address indexes a zero bit instead of running off the vector.
    logic [PAD-1:0] full_pad;
    logic [PAD-1:0] empty_pad;
    logic [PAD-1:0] srst_pad;

    logic full_dest;
    logic empty_dest;
    logic empty_new;
    logic srst_dest;
    logic addr_ok;
    logic wait_expired;

    assign full_pad   = PAD'(bus.fifo_full);
    assign empty_pad  = PAD'(bus.fifo_empty);
    assign srst_pad   = PAD'(bus.soft_rst);
    assign full_dest  = full_pad[dest_port_q];
    assign empty_dest = empty_pad[dest_port_q];
    assign srst_dest  = srst_pad[dest_port_q];
    assign empty_new  = empty_pad[bus.data_in];
    assign addr_ok    = (32'(bus.data_in) < NUM_PORTS);

    assign wait_expired = (WAIT_LIMIT != 0) && (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

    always_comb begin
        next_state = DA;
        if (state != DA && srst_dest) begin
            next_state = DA;
        end else begin
            case (state)
                DA: begin
                    if (!bus.pkt_valid)  next_state = DA;
                    else if (!addr_ok)   next_state = DROP;
                    else if (empty_new)  next_state = LFD;
                    else                 next_state = WTE;
                end
                LFD: next_state = LD;
                LD: begin
                    if (full_dest)           next_state = FFS;
                    else if (!bus.pkt_valid) next_state = LP;
                    else                     next_state = LD;
                end
                FFS: next_state = full_dest ? FFS : LAF;
                LAF: begin
                    if (bus.parity_done)        next_state = DA;
                    else if (bus.low_pkt_valid) next_state = LP;
                    else                        next_state = LD;
                end
                LP:  next_state = CPE;
                CPE: next_state = full_dest ? FFS : DA;
                WTE: begin
                    if (empty_dest)        next_state = LFD;
                    else if (wait_expired) next_state = DROP;
                    else                   next_state = WTE;
                end
                DROP:    next_state = bus.pkt_valid ? DROP : DA;
                default: next_state = DA;
            endcase
        end
    end

    assign out_state = rst ? DA : next_state;

    always_ff @(posedge clk) begin
        state <= out_state;

        // Flags decode the state being entered so they line up with it.
        detect_addr_q <= (out_state == DA);
        lfd_q         <= (out_state == LFD);
        ld_q          <= (out_state == LD);
        laf_q         <= (out_state == LAF);
        full_q        <= (out_state == FFS);
        rst_int_q     <= (out_state == CPE);
        drop_q        <= (out_state == DROP);
        write_enb_q   <= (out_state inside {LD, LP, LAF});
        busy_q        <= (out_state inside {LFD, LP, FFS, LAF, WTE, CPE});

        if (rst) begin
            dest_port_q <= '0;
            wait_cnt    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (state == DA && bus.pkt_valid)
                dest_port_q <= bus.data_in;

            if (state == WTE) wait_cnt <= wait_cnt + 1'b1;
            else              wait_cnt <= '0;

            if (next_state == DROP && state != DROP && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.detect_addr   = detect_addr_q;
    assign bus.lfd_state     = lfd_q;
    assign bus.ld_state      = ld_q;
    assign bus.laf_state     = laf_q;
    assign bus.full_state    = full_q;
    assign bus.rst_int_reg   = rst_int_q;
    assign bus.write_enb_reg = write_enb_q;
    assign bus.drop_state    = drop_q;
    assign bus.dest_port     = dest_port_q;
    assign bus.drop_cnt      = drop_cnt_q;
endmodule
